// File: rtl/sync_arith_pkg.sv
// rtl/sync_arith_pkg.sv - shared ALU status/entry types for the result buffer
package sync_arith_pkg;

  localparam int STATUS_W = 4;
  localparam int ALU_BITS = 32;

  typedef logic [STATUS_W-1:0] alu_status_t;

  typedef struct packed {
    alu_status_t         status;
    logic [ALU_BITS-1:0] result;
  } alu_entry_t;

endpackage

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - generic show-ahead circular FIFO with count and full/empty
module sync_fifo_core #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Control state register; full/empty registered with count so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array is not reset; stale contents are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/sync_arith_result_buffer.sv
// rtl/sync_arith_result_buffer.sv - ALU result FIFO with sticky status and overflow flag
module sync_arith_result_buffer
  import sync_arith_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_valid,
  input  logic [BITS-1:0]     i_result,
  input  logic [STATUS_W-1:0] i_status,
  output logic                o_rd_valid,
  input  logic                i_rd_ready,
  output logic [BITS-1:0]     o_rd_result,
  output logic [STATUS_W-1:0] o_rd_status,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_full,
  output logic                o_empty,
  output logic [STATUS_W-1:0] o_sticky_status,
  input  logic                i_clr_sticky,
  output logic                o_overflow
);

  // Entry built locally so BITS may differ from the package default.
  typedef struct packed {
    alu_status_t     status;
    logic [BITS-1:0] result;
  } entry_t;

  entry_t      wr_entry, rd_entry;
  logic        push, pop, drop;
  logic        full, empty;
  alu_status_t sticky_q, sticky_d;
  logic        overflow_q, overflow_d;

  // Handshake decode: a pop while full frees the slot the concurrent write needs.
  always_comb begin
    pop  = !empty && i_rd_ready;
    push = i_wr_valid && (!full || pop);
    drop = i_wr_valid && full && !pop;
  end

  assign wr_entry = '{status: i_status, result: i_result};

  sync_fifo_core #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (o_count),
    .full    (full),
    .empty   (empty)
  );

  // Sticky flags: clear first, then fold in this cycle's event so new events win.
  always_comb begin
    sticky_d   = i_clr_sticky ? '0 : sticky_q;
    overflow_d = i_clr_sticky ? 1'b0 : overflow_q;
    if (push) sticky_d = sticky_d | i_status;
    if (drop) overflow_d = 1'b1;
  end

  // Sticky flag registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sticky_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_rd_valid      = !empty;
  assign o_rd_result     = rd_entry.result;
  assign o_rd_status     = rd_entry.status;
  assign o_full          = full;
  assign o_empty         = empty;
  assign o_sticky_status = sticky_q;
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_sync_arith_result_buffer.sv
// tb/tb_sync_arith_result_buffer.sv - directed self-checking bench for sync_arith_result_buffer
module tb_sync_arith_result_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_wr_valid;
  logic [31:0] i_result;
  logic [3:0]  i_status;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [31:0] o_rd_result;
  logic [3:0]  o_rd_status;
  logic [3:0]  o_count;
  logic        o_full;
  logic        o_empty;
  logic [3:0]  o_sticky_status;
  logic        i_clr_sticky;
  logic        o_overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  sync_arith_result_buffer #(.BITS(32), .DEPTH(8)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_wr_valid      (i_wr_valid),
    .i_result        (i_result),
    .i_status        (i_status),
    .o_rd_valid      (o_rd_valid),
    .i_rd_ready      (i_rd_ready),
    .o_rd_result     (o_rd_result),
    .o_rd_status     (o_rd_status),
    .o_count         (o_count),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_sticky_status (o_sticky_status),
    .i_clr_sticky    (i_clr_sticky),
    .o_overflow      (o_overflow)
  );

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_wr_valid   = 1'b0;
    i_result     = '0;
    i_status     = '0;
    i_rd_ready   = 1'b0;
    i_clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1'b0;
    step();
    step();
    n_vec++;
    if ({o_empty, o_full, o_rd_valid, o_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_flags: got e=%b f=%b v=%b cnt=%0d, want e=1 f=0 v=0 cnt=0", o_empty, o_full, o_rd_valid, o_count);
    end
    n_vec++;
    if ({o_rd_result, o_rd_status, o_sticky_status, o_overflow} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_data: got res=%h st=%h sticky=%h ovf=%b, want all 0", o_rd_result, o_rd_status, o_sticky_status, o_overflow);
    end
    i_reset = 1'b1;
    step();
    n_vec++;
    if (o_empty !== 1'b1 || o_count !== 4'd0) begin
      n_err++;
      $display("FAIL reset_idle: got e=%b cnt=%0d, want e=1 cnt=0", o_empty, o_count);
    end
  endtask

  task automatic test_single_write();
    i_wr_valid = 1'b1; i_result = 32'h5; i_status = 4'b0001;
    step();
    idle_inputs();
    n_vec++;
    if ({o_rd_valid, o_rd_result, o_rd_status, o_count, o_sticky_status} !== {1'b1, 32'h5, 4'h1, 4'd1, 4'b0001}) begin
      n_err++;
      $display("FAIL single_write: got v=%b res=%h st=%h cnt=%0d sticky=%b, want v=1 res=5 st=1 cnt=1 sticky=0001",
               o_rd_valid, o_rd_result, o_rd_status, o_count, o_sticky_status);
    end
    i_rd_ready = 1'b1;
    step();
    idle_inputs();
    n_vec++;
    if (o_empty !== 1'b1 || o_rd_result !== 32'h0 || o_count !== 4'd0) begin
      n_err++;
      $display("FAIL single_pop: got e=%b res=%h cnt=%0d, want e=1 res=0 cnt=0", o_empty, o_rd_result, o_count);
    end
    i_clr_sticky = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      i_wr_valid = 1'b1; i_result = i; i_status = 4'b0000;
      step();
    end
    idle_inputs();
    n_vec++;
    if ({o_full, o_overflow, o_count} !== {1'b1, 1'b1, 4'd8}) begin
      n_err++;
      $display("FAIL overflow: got f=%b ovf=%b cnt=%0d, want f=1 ovf=1 cnt=8", o_full, o_overflow, o_count);
    end
    // Clear together with another dropped write: the drop wins, and its status is ignored.
    i_clr_sticky = 1'b1; i_wr_valid = 1'b1; i_result = 32'h77; i_status = 4'b1111;
    step();
    idle_inputs();
    n_vec++;
    if (o_overflow !== 1'b1 || o_sticky_status !== 4'b0000 || o_count !== 4'd8) begin
      n_err++;
      $display("FAIL clr_with_drop: got ovf=%b sticky=%b cnt=%0d, want ovf=1 sticky=0000 cnt=8", o_overflow, o_sticky_status, o_count);
    end
    for (int i = 1; i <= 8; i++) begin
      n_vec++;
      if (o_rd_valid !== 1'b1 || o_rd_result !== 32'(i)) begin
        n_err++;
        $display("FAIL drain_order[%0d]: got v=%b res=%h, want v=1 res=%h", i, o_rd_valid, o_rd_result, i);
      end
      i_rd_ready = 1'b1;
      step();
    end
    idle_inputs();
    n_vec++;
    if (o_empty !== 1'b1 || o_rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: got e=%b v=%b res=%h, want e=1 v=0 (entry 9 must not appear)", o_empty, o_rd_valid, o_rd_result);
    end
    i_clr_sticky = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 8; i++) begin
      i_wr_valid = 1'b1; i_result = 32'h10 + i; i_status = 4'b0000;
      step();
    end
    i_wr_valid = 1'b1; i_result = 32'hAA; i_rd_ready = 1'b1;
    step();
    idle_inputs();
    n_vec++;
    if ({o_full, o_overflow, o_count} !== {1'b1, 1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL full_simul: got f=%b ovf=%b cnt=%0d, want f=1 ovf=0 cnt=8", o_full, o_overflow, o_count);
    end
    for (int i = 2; i <= 9; i++) begin
      n_vec++;
      if (o_rd_result !== ((i == 9) ? 32'hAA : 32'h10 + i)) begin
        n_err++;
        $display("FAIL full_simul_drain[%0d]: got res=%h, want %h", i, o_rd_result, (i == 9) ? 32'hAA : 32'h10 + i);
      end
      i_rd_ready = 1'b1;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int rd_idx = 0;
    int guard = 0;
    for (int i = 0; i < 20; i++) begin
      i_wr_valid = 1'b1; i_result = 32'd100 + i; i_status = 4'b0000; i_rd_ready = 1'b1;
      if (o_rd_valid) begin
        n_vec++;
        if (o_rd_result !== 32'd100 + rd_idx) begin
          n_err++;
          $display("FAIL b2b[%0d]: got res=%0d, want %0d", rd_idx, o_rd_result, 100 + rd_idx);
        end
        rd_idx++;
      end
      step();
    end
    i_wr_valid = 1'b0;
    while (o_rd_valid && guard < 30) begin
      n_vec++;
      if (o_rd_result !== 32'd100 + rd_idx) begin
        n_err++;
        $display("FAIL b2b[%0d]: got res=%0d, want %0d", rd_idx, o_rd_result, 100 + rd_idx);
      end
      rd_idx++;
      guard++;
      step();
    end
    idle_inputs();
    n_vec++;
    if (rd_idx != 20 || o_count !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_total: got reads=%0d cnt=%0d, want reads=20 cnt=0", rd_idx, o_count);
    end
  endtask

  task automatic test_sticky();
    i_clr_sticky = 1'b1;
    step();
    idle_inputs();
    i_wr_valid = 1'b1; i_result = 32'h1; i_status = 4'b0010;
    step();
    i_result = 32'h2; i_status = 4'b1000;
    step();
    idle_inputs();
    n_vec++;
    if (o_sticky_status !== 4'b1010 || o_count !== 4'd2) begin
      n_err++;
      $display("FAIL sticky_or: got sticky=%b cnt=%0d, want sticky=1010 cnt=2", o_sticky_status, o_count);
    end
    i_clr_sticky = 1'b1; i_wr_valid = 1'b1; i_result = 32'h3; i_status = 4'b0100;
    step();
    idle_inputs();
    n_vec++;
    if (o_sticky_status !== 4'b0100 || o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clr_push: got sticky=%b ovf=%b, want sticky=0100 ovf=0", o_sticky_status, o_overflow);
    end
    n_vec++;
    if (o_rd_status !== 4'b0010 || o_rd_result !== 32'h1) begin
      n_err++;
      $display("FAIL sticky_head: got st=%b res=%h, want st=0010 res=1", o_rd_status, o_rd_result);
    end
  endtask

  task automatic test_reset_mid();
    // Three entries from test_sticky remain stored.
    n_vec++;
    if (o_count !== 4'd3) begin
      n_err++;
      $display("FAIL pre_reset_count: got %0d, want 3", o_count);
    end
    #2;
    i_reset = 1'b0;
    #1;
    n_vec++;
    if ({o_rd_valid, o_count, o_rd_result, o_sticky_status, o_empty} !== {1'b0, 4'd0, 32'd0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b cnt=%0d res=%h sticky=%b e=%b, want v=0 cnt=0 res=0 sticky=0 e=1",
               o_rd_valid, o_count, o_rd_result, o_sticky_status, o_empty);
    end
    step();
    i_reset = 1'b1;
    step();
    n_vec++;
    if (o_count !== 4'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got cnt=%0d e=%b v=%b, want cnt=0 e=1 v=0", o_count, o_empty, o_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_full_simul();
    test_back_to_back();
    test_sticky();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_arith_result_buffer.md
Name: sync_arith_result_buffer

Overview:
- Downstream stage of sync_arith_unit_12: captures each registered o_result/o_status pair from the ALU into a show-ahead FIFO.
- Presents captured pairs to the consumer with a valid/ready handshake.
- Keeps sticky status flags and an overflow indicator, so a slow consumer never loses results silently.

Parameters:
- BITS, 32, width of the ALU result word; must match sync_arith_unit_12 BITS.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of o_count.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  reset, asynchronous and active-low.
- i_wr_valid  input  1  ALU result on i_result/i_status is valid this cycle.
- i_result  input  BITS  ALU o_result.
- i_status  input  4  ALU o_status.
- o_rd_valid  output  1  head entry available (FIFO not empty).
- i_rd_ready  input  1  consumer accepts the head entry.
- o_rd_result  output  BITS  head entry result.
- o_rd_status  output  4  head entry status.
- o_count  output  CNT_W  number of stored entries, 0..DEPTH.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_sticky_status  output  4  OR of i_status over all accepted writes since last clear.
- i_clr_sticky  input  1  synchronous clear of o_sticky_status and o_overflow.
- o_overflow  output  1  sticky: at least one write was dropped.

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_count=0, o_empty=1, o_full=0, o_rd_valid=0.
  - o_rd_result=0, o_rd_status=0, o_sticky_status=0, o_overflow=0.
  - Read and write pointers = 0.
  - Memory contents are not reset, but outputs are masked to 0 while empty.
- Reset asserted mid-operation discards all entries immediately. The first edge after release is a normal cycle.
- Storage: circular buffer of DEPTH entries {status, result}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Pop: pop = o_rd_valid && i_rd_ready. On pop, rd_ptr advances.
- Push: push = i_wr_valid && (!o_full || pop).
  - When full, a simultaneous pop frees a slot, so the write is accepted.
- Drop: i_wr_valid && o_full && !pop → data discarded, o_overflow set to 1; count and pointers unchanged.
- Count: push&&!pop → count+1; pop&&!push → count−1; both or neither → unchanged.
- Show-ahead read:
  - o_rd_result/o_rd_status are driven combinationally from mem[rd_ptr] when !o_empty, else 0.
  - Write-to-read latency: an entry written at edge N is visible on o_rd_* after edge N (one cycle) when the FIFO was empty.
  - No same-cycle bypass.
- Push and pop on an empty FIFO: pop is impossible (o_rd_valid=0), so only the push happens.
- Sticky status: on each accepted push, o_sticky_status |= i_status. Dropped writes do not contribute.
- i_clr_sticky:
  - Clears o_sticky_status and o_overflow at the next edge.
  - If an accepted push occurs in the same cycle, the result is that push's i_status (clear then OR).
  - If a drop occurs in the same cycle, o_overflow ends as 1 (the new event wins).
- o_full/o_empty are registered alongside count and are consistent with o_count in every cycle.
- i_rd_ready while empty has no effect.

Decomposition:
- Shared package sync_arith_pkg:
  - localparam STATUS_W=4.
  - typedef alu_status_t (logic [3:0]).
  - typedef packed struct alu_entry_t {alu_status_t status; logic [BITS-1:0] result} with BITS fixed at the package default of 32.
  - The module may instead build the entry locally when BITS is overridden.
- One natural sub-module: sync_fifo_core (generic width/depth storage with pointers, count and full/empty, push/pop interface).
  - The top adds the drop logic, sticky status and overflow.

Test Plan:
- Reset, then idle → o_empty=1, o_count=0, o_rd_valid=0, o_rd_result=0, o_sticky_status=0.
- Write 0x0000_0005/status 4'b0001, i_rd_ready=0 → next cycle o_rd_valid=1, o_rd_result=0x5, o_rd_status=1, o_count=1, o_sticky_status=4'b0001.
- Write 8 values 1..8 with no read, then a 9th value 9 → o_full=1, o_overflow=1, o_count=8; drain yields 1..8 in order and 9 never appears.
- Full FIFO with i_wr_valid and i_rd_ready together, data 0xAA → count stays 8, no overflow, 0xAA emerges last.
- Write 20 entries while reading every cycle → pointers wrap and order is preserved.
- Statuses 4'b0010 then 4'b1000 → sticky=4'b1010. Then i_clr_sticky with a concurrent write of 4'b0100 → sticky=4'b0100.
- Assert i_reset low with 3 entries stored, between clock edges → outputs zero immediately; after release o_count=0.
